striping_rr: RTL and testbench
==============================

Name: striping_rr

Overview:
- Parametrised round-robin striper that distributes a serial word stream across LANES parallel lanes on clk_2f.
- Generalises the fixed two-lane toggle striper in three ways: configurable lane count and data width, per-lane backpressure, and a selectable idle policy.
- Sits between the byte/word source and the per-lane transmit paths; its output feeds the downstream lane serialisers and the unstriper.

Parameters:
- DATA_W, 32, width of each data word in bits.
- LANES, 4, number of output lanes; legal range 2..8; need not be a power of two.
- SKIP_IDLE, 0, idle policy. 0 = the pointer advances every cycle, including idle slots (fixed rotation). 1 = the pointer advances only on an accepted word (packed rotation).
- PTR_W, derived localparam = clog2(LANES), width of the lane pointer.

Ports:
- clk_2f, in, 1, clock, 2x the lane rate.
- reset, in, 1, synchronous, active-high.
- data_in, in, DATA_W, input word.
- valid_in, in, 1, data_in is valid this cycle.
- in_ready, out, 1, combinational; the current lane can accept a word.
- lane_ready, in, LANES, per-lane downstream ready; bit i belongs to lane i.
- lane_data, out, LANES*DATA_W, flattened lane words; lane i occupies bits [i*DATA_W +: DATA_W].
- lane_valid, out, LANES, per-lane valid.
- lane_ptr, out, PTR_W, current lane pointer (registered).
- group_start, out, 1, one-cycle pulse when a word has been written to lane 0.

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk_2f. Reset has priority over all other activity, including mid-operation.
- Reset values: ptr=0, lane_data=0, lane_valid=0, group_start=0.
- in_ready = lane_ready[ptr] (pure combinational, no dependence on valid_in).
- accept = valid_in & in_ready.
- Per-cycle action at the rising edge, where p is the current ptr:
  - accept: lane_data[p] <= data_in; lane_valid[p] <= 1; ptr <= next(p). Latency is one cycle from data_in to lane_data.
  - valid_in & !lane_ready[p] (stall): ptr, lane_data and lane_valid are all held, in both modes. The source must hold data_in until accept.
  - !valid_in, SKIP_IDLE=0: lane_valid[p] <= 0; lane_data[p] holds; ptr <= next(p).
  - !valid_in, SKIP_IDLE=1: ptr holds; lane_valid and lane_data hold.
- Lanes other than p are never modified in a cycle; their valid and data persist until their own slot comes round.
- next(p) = (p == LANES-1) ? 0 : p+1. The explicit compare is required so that non-power-of-two LANES wraps correctly and ptr never reaches values >= LANES.
- group_start <= accept & (p == 0); deasserts the following cycle unless lane 0 accepts again, which for LANES>=2 is impossible on consecutive cycles.
- When LANES=2 and SKIP_IDLE=0 with lane_ready all 1, lane_data and lane_valid must match the legacy two-lane striper cycle for cycle.
- lane_ready bits for lanes other than p have no effect in that cycle.
- If reset is deasserted while valid_in=1, the first accepted word goes to lane 0.

Decomposition:
- Package striping_pkg:
  - DEFAULT_DATA_W = 32, MAX_LANES = 8.
  - Idle-mode constants MODE_FIXED = 0 and MODE_SKIP = 1.
  - Function ptr_next(p, lanes).
- Sub-module striping_lane_ptr: a wrap-around counter with inputs clk_2f, reset, en, and output ptr, parameterised by LANES. It is reused by the unstriper.
- Lane registers use a generate loop in striping_rr.

Test Plan:
1. LANES=4, SKIP_IDLE=0, lane_ready=4'hF, words 0xA0..0xA7 on consecutive cycles -> lane0 gets 0xA0 then 0xA4, lane1 0xA1/0xA5, lane2 0xA2/0xA6, lane3 0xA3/0xA7; lane_valid=4'hF from cycle 4; group_start pulses in cycles 1 and 5.
2. LANES=4, SKIP_IDLE=0, valid pattern 1,0,1,1 with data 0x11,x,0x33,0x44 -> lane_valid[1]=0, lane1 data unchanged, lane2=0x33, lane3=0x44, ptr sequence 0,1,2,3,0.
3. Same pattern with SKIP_IDLE=1 -> lane0=0x11, lane1=0x33, lane2=0x44, ptr stays 1 during the idle cycle, lane_valid=4'b0111.
4. LANES=3, 7 consecutive accepted words -> ptr sequence 0,1,2,0,1,2,0; ptr never equals 3; group_start pulses after words 1, 4 and 7.
5. LANES=4, lane_ready[2]=0 for 3 cycles while valid_in=1 and data_in=0x55 is held -> in_ready=0, ptr stays 2, outputs frozen; on lane_ready[2]=1, lane2=0x55 the next cycle and ptr=3.
6. Reset asserted mid-stream with ptr=2 -> next cycle ptr=0, all lane_data=0, lane_valid=0, group_start=0; LANES=2, SKIP_IDLE=0 run compared cycle-accurately against the legacy two-lane striper.

Source files
------------

// File: rtl/striping_pkg.sv
// Shared constants and helpers for the lane striper and unstriper.
// The pointer wrap is an explicit compare so non-power-of-two lane counts wrap correctly.
package striping_pkg;

   localparam int DEFAULT_DATA_W = 32;
   localparam int MAX_LANES      = 8;

   localparam int MODE_FIXED = 0;
   localparam int MODE_SKIP  = 1;

   function automatic int unsigned ptr_next(input int unsigned p, input int unsigned lanes);
      return (p == lanes - 32'd1) ? 32'd0 : p + 32'd1;
   endfunction

endpackage

// File: rtl/striping_lane_ptr.sv
// Wrap-around lane pointer; advances on en and wraps from LANES-1 to 0.
// Shared with the unstriper so both sides rotate identically.
module striping_lane_ptr
   import striping_pkg::*;
#(
   parameter  int LANES = 4,
   localparam int PTR_W = $clog2(LANES)
) (
   input  logic             clk_2f,
   input  logic             reset,
   input  logic             en,
   output logic [PTR_W-1:0] ptr
);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;

   always_comb begin
      ptr_d = ptr_q;
      if (en) begin
         ptr_d = PTR_W'(ptr_next(32'(ptr_q), 32'(LANES)));
      end
   end

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/striping_rr.sv
// Round-robin striper: spreads a serial word stream over LANES output lanes
// with per-lane backpressure and a fixed or packed idle rotation.
module striping_rr
   import striping_pkg::*;
#(
   parameter  int DATA_W    = DEFAULT_DATA_W,
   parameter  int LANES     = 4,
   parameter  int SKIP_IDLE = MODE_FIXED,
   localparam int PTR_W     = $clog2(LANES)
) (
   input  logic                    clk_2f,
   input  logic                    reset,
   input  logic [DATA_W-1:0]       data_in,
   input  logic                    valid_in,
   output logic                    in_ready,
   input  logic [LANES-1:0]        lane_ready,
   output logic [LANES*DATA_W-1:0] lane_data,
   output logic [LANES-1:0]        lane_valid,
   output logic [PTR_W-1:0]        lane_ptr,
   output logic                    group_start
);

   localparam bit FIXED_ROT = (SKIP_IDLE == MODE_FIXED);

   logic accept;
   logic idle;
   logic advance;
   logic group_start_q;
   logic group_start_d;

   // Explicit select avoids indexing past LANES-1 when LANES is not a power of two.
   always_comb begin
      in_ready = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (lane_ptr == PTR_W'(i)) begin
            in_ready = lane_ready[i];
         end
      end
   end

   assign accept  = valid_in & in_ready;
   assign idle    = ~valid_in;
   assign advance = accept | (idle & FIXED_ROT);

   striping_lane_ptr #(
      .LANES (LANES)
   ) u_lane_ptr (
      .clk_2f (clk_2f),
      .reset  (reset),
      .en     (advance),
      .ptr    (lane_ptr)
   );

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic              sel;
      logic [DATA_W-1:0] data_q;
      logic [DATA_W-1:0] data_d;
      logic              valid_q;
      logic              valid_d;

      assign sel = (lane_ptr == PTR_W'(i));

      always_comb begin
         data_d  = data_q;
         valid_d = valid_q;
         if (sel && accept) begin
            data_d  = data_in;
            valid_d = 1'b1;
         end else if (sel && idle && FIXED_ROT) begin
            valid_d = 1'b0;
         end
      end

      always_ff @(posedge clk_2f) begin
         if (reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
         end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
         end
      end

      assign lane_data[i*DATA_W +: DATA_W] = data_q;
      assign lane_valid[i]                 = valid_q;
   end

   assign group_start_d = accept & (lane_ptr == '0);

   always_ff @(posedge clk_2f) begin
      if (reset) begin
         group_start_q <= 1'b0;
      end else begin
         group_start_q <= group_start_d;
      end
   end

   assign group_start = group_start_q;

endmodule

// File: tb/tb_striping_rr.sv
// Bench for striping_rr: four configurations share one stimulus stream and are
// checked against an array-based reference of the striping rules.
module tb_striping_rr;
   import striping_pkg::*;

   localparam int NI = 4;

   logic        clk_2f;
   logic        reset;
   logic [31:0] data_in;
   logic        valid_in;
   logic [7:0]  rdy [NI];

   logic [127:0] ld0;  logic [3:0] lv0;  logic [1:0] lp0;  logic gs0, ir0;
   logic [127:0] ld1;  logic [3:0] lv1;  logic [1:0] lp1;  logic gs1, ir1;
   logic [95:0]  ld2;  logic [2:0] lv2;  logic [1:0] lp2;  logic gs2, ir2;
   logic [63:0]  ld3;  logic [1:0] lv3;  logic [0:0] lp3;  logic gs3, ir3;

   logic [255:0] o_ld  [NI];
   logic [7:0]   o_lv  [NI];
   logic [2:0]   o_ptr [NI];
   logic         o_gs  [NI];
   logic         o_ir  [NI];

   logic [31:0] md [NI][8];
   logic        mv [NI][8];
   int          mp [NI];
   logic        mg [NI];

   int n_cmp = 0;
   int n_bad = 0;

   striping_rr #(.DATA_W(32), .LANES(4), .SKIP_IDLE(MODE_FIXED)) u_4f (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .in_ready(ir0), .lane_ready(rdy[0][3:0]), .lane_data(ld0), .lane_valid(lv0),
      .lane_ptr(lp0), .group_start(gs0));

   striping_rr #(.DATA_W(32), .LANES(4), .SKIP_IDLE(MODE_SKIP)) u_4s (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .in_ready(ir1), .lane_ready(rdy[1][3:0]), .lane_data(ld1), .lane_valid(lv1),
      .lane_ptr(lp1), .group_start(gs1));

   striping_rr #(.DATA_W(32), .LANES(3), .SKIP_IDLE(MODE_FIXED)) u_3f (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .in_ready(ir2), .lane_ready(rdy[2][2:0]), .lane_data(ld2), .lane_valid(lv2),
      .lane_ptr(lp2), .group_start(gs2));

   striping_rr #(.DATA_W(32), .LANES(2), .SKIP_IDLE(MODE_FIXED)) u_2f (
      .clk_2f(clk_2f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
      .in_ready(ir3), .lane_ready(rdy[3][1:0]), .lane_data(ld3), .lane_valid(lv3),
      .lane_ptr(lp3), .group_start(gs3));

   assign o_ld[0] = 256'(ld0);  assign o_lv[0] = 8'(lv0);  assign o_ptr[0] = 3'(lp0);
   assign o_ld[1] = 256'(ld1);  assign o_lv[1] = 8'(lv1);  assign o_ptr[1] = 3'(lp1);
   assign o_ld[2] = 256'(ld2);  assign o_lv[2] = 8'(lv2);  assign o_ptr[2] = 3'(lp2);
   assign o_ld[3] = 256'(ld3);  assign o_lv[3] = 8'(lv3);  assign o_ptr[3] = 3'(lp3);
   assign o_gs[0] = gs0;  assign o_gs[1] = gs1;  assign o_gs[2] = gs2;  assign o_gs[3] = gs3;
   assign o_ir[0] = ir0;  assign o_ir[1] = ir1;  assign o_ir[2] = ir2;  assign o_ir[3] = ir3;

   initial clk_2f = 1'b0;
   always #5 clk_2f = ~clk_2f;

   function automatic int lanes_of(input int m);
      case (m)
         2:       return 3;
         3:       return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit skip_of(input int m);
      return (m == 1);
   endfunction

   // Advance one clock and apply the striping rules to every reference lane set.
   task automatic step();
      @(posedge clk_2f);
      for (int m = 0; m < NI; m++) begin
         int p = mp[m];
         if (reset) begin
            mp[m] = 0;
            mg[m] = 1'b0;
            for (int k = 0; k < 8; k++) begin
               md[m][k] = '0;
               mv[m][k] = 1'b0;
            end
         end else if (valid_in && rdy[m][p]) begin
            md[m][p] = data_in;
            mv[m][p] = 1'b1;
            mg[m]    = (p == 0);
            mp[m]    = (p + 1) % lanes_of(m);
         end else begin
            mg[m] = 1'b0;
            if (!valid_in && !skip_of(m)) begin
               mv[m][p] = 1'b0;
               mp[m]    = (p + 1) % lanes_of(m);
            end
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      for (int m = 0; m < NI; m++) rdy[m] = 8'hFF;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      for (int m = 0; m < NI; m++) begin
         n_cmp++;
         if (o_ptr[m] !== 3'd0) begin
            n_bad++; $display("FAIL reset_ptr[%0d]: got %0d want 0", m, o_ptr[m]);
         end
         n_cmp++;
         if (o_lv[m] !== 8'h00) begin
            n_bad++; $display("FAIL reset_valid[%0d]: got %h want 00", m, o_lv[m]);
         end
         n_cmp++;
         if (o_ld[m] !== 256'd0) begin
            n_bad++; $display("FAIL reset_data[%0d]: got %h want 0", m, o_ld[m]);
         end
         n_cmp++;
         if (o_gs[m] !== 1'b0) begin
            n_bad++; $display("FAIL reset_gs[%0d]: got %b want 0", m, o_gs[m]);
         end
      end
   endtask

   task automatic test_fixed_rotation();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         data_in  = 32'hA0 + 32'(i);
         valid_in = 1'b1;
         step();
         n_cmp++;
         if (o_ld[0][(i%4)*32 +: 32] !== 32'hA0 + 32'(i)) begin
            n_bad++; $display("FAIL rot_data w%0d: got %h want %h", i, o_ld[0][(i%4)*32 +: 32], 32'hA0 + 32'(i));
         end
         n_cmp++;
         if (o_gs[0] !== 1'((i % 4) == 0)) begin
            n_bad++; $display("FAIL rot_gs w%0d: got %b want %b", i, o_gs[0], (i % 4) == 0);
         end
         if (i >= 3) begin
            n_cmp++;
            if (o_lv[0] !== 8'h0F) begin
               n_bad++; $display("FAIL rot_valid w%0d: got %h want 0f", i, o_lv[0]);
            end
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_idle_policy();
      logic [31:0] dv [4];
      logic        vv [4];
      int          pf [4];
      int          ps [4];
      dv = '{32'h11, $urandom, 32'h33, 32'h44};
      vv = '{1'b1, 1'b0, 1'b1, 1'b1};
      pf = '{1, 2, 3, 0};
      ps = '{1, 1, 2, 3};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         data_in  = dv[i];
         valid_in = vv[i];
         step();
         n_cmp++;
         if (o_ptr[0] !== 3'(pf[i])) begin
            n_bad++; $display("FAIL idle_fixed_ptr c%0d: got %0d want %0d", i, o_ptr[0], pf[i]);
         end
         n_cmp++;
         if (o_ptr[1] !== 3'(ps[i])) begin
            n_bad++; $display("FAIL idle_skip_ptr c%0d: got %0d want %0d", i, o_ptr[1], ps[i]);
         end
      end
      valid_in = 1'b0;
      n_cmp++;
      if (o_lv[0] !== 8'b1101 || o_ld[0][127:0] !== {32'h44, 32'h33, 32'h0, 32'h11}) begin
         n_bad++; $display("FAIL idle_fixed_lanes: got v=%h d=%h want v=0d d=%h", o_lv[0], o_ld[0][127:0], {32'h44, 32'h33, 32'h0, 32'h11});
      end
      n_cmp++;
      if (o_lv[1] !== 8'b0111 || o_ld[1][127:0] !== {32'h0, 32'h44, 32'h33, 32'h11}) begin
         n_bad++; $display("FAIL idle_skip_lanes: got v=%h d=%h want v=07 d=%h", o_lv[1], o_ld[1][127:0], {32'h0, 32'h44, 32'h33, 32'h11});
      end
   endtask

   task automatic test_three_lanes();
      logic [31:0] w [7];
      do_reset();
      for (int i = 0; i < 7; i++) begin
         w[i]     = $urandom;
         data_in  = w[i];
         valid_in = 1'b1;
         step();
         n_cmp++;
         if (o_ptr[2] !== 3'((i + 1) % 3)) begin
            n_bad++; $display("FAIL l3_ptr w%0d: got %0d want %0d", i, o_ptr[2], (i + 1) % 3);
         end
         n_cmp++;
         if (o_gs[2] !== 1'((i % 3) == 0)) begin
            n_bad++; $display("FAIL l3_gs w%0d: got %b want %b", i, o_gs[2], (i % 3) == 0);
         end
         n_cmp++;
         if (o_ld[2][(i%3)*32 +: 32] !== w[i]) begin
            n_bad++; $display("FAIL l3_data w%0d: got %h want %h", i, o_ld[2][(i%3)*32 +: 32], w[i]);
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_backpressure();
      logic [31:0] w0, w1;
      do_reset();
      w0 = $urandom;  w1 = $urandom;
      valid_in = 1'b1;
      data_in  = w0;  step();
      data_in  = w1;  step();
      data_in  = 32'h55;
      rdy[0]   = 8'hFB;
      for (int c = 0; c < 3; c++) begin
         #1;
         n_cmp++;
         if (o_ir[0] !== 1'b0) begin
            n_bad++; $display("FAIL bp_ready c%0d: got %b want 0", c, o_ir[0]);
         end
         step();
         n_cmp++;
         if (o_ptr[0] !== 3'd2 || o_lv[0] !== 8'h03 || o_ld[0][127:0] !== {64'h0, w1, w0}) begin
            n_bad++; $display("FAIL bp_hold c%0d: got p=%0d v=%h d=%h want p=2 v=03 d=%h", c, o_ptr[0], o_lv[0], o_ld[0][127:0], {64'h0, w1, w0});
         end
      end
      rdy[0] = 8'hFF;
      #1;
      n_cmp++;
      if (o_ir[0] !== 1'b1) begin
         n_bad++; $display("FAIL bp_release_ready: got %b want 1", o_ir[0]);
      end
      step();
      valid_in = 1'b0;
      n_cmp++;
      if (o_ld[0][95:64] !== 32'h55 || o_ptr[0] !== 3'd3 || o_lv[0] !== 8'h07) begin
         n_bad++; $display("FAIL bp_release: got d2=%h p=%0d v=%h want d2=55 p=3 v=07", o_ld[0][95:64], o_ptr[0], o_lv[0]);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      valid_in = 1'b1;
      data_in  = $urandom;  step();
      data_in  = $urandom;  step();
      n_cmp++;
      if (o_ptr[0] !== 3'd2) begin
         n_bad++; $display("FAIL mid_pre_ptr: got %0d want 2", o_ptr[0]);
      end
      reset   = 1'b1;
      data_in = $urandom;
      step();
      for (int m = 0; m < NI; m++) begin
         n_cmp++;
         if (o_ptr[m] !== 3'd0 || o_lv[m] !== 8'h00 || o_ld[m] !== 256'd0 || o_gs[m] !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset[%0d]: got p=%0d v=%h gs=%b d=%h want all zero", m, o_ptr[m], o_lv[m], o_gs[m], o_ld[m]);
         end
      end
      reset   = 1'b0;
      data_in = 32'h77;
      step();
      valid_in = 1'b0;
      n_cmp++;
      if (o_ld[0][31:0] !== 32'h77 || o_ptr[0] !== 3'd1 || o_gs[0] !== 1'b1) begin
         n_bad++; $display("FAIL mid_first_word: got d0=%h p=%0d gs=%b want d0=77 p=1 gs=1", o_ld[0][31:0], o_ptr[0], o_gs[0]);
      end
   endtask

   // Two-lane toggle behaviour: select flips every cycle, idle clears the selected valid.
   task automatic test_legacy();
      logic        sel;
      logic [31:0] l_d [2];
      logic        l_v [2];
      do_reset();
      sel = 1'b0;
      l_d = '{32'h0, 32'h0};
      l_v = '{1'b0, 1'b0};
      for (int c = 0; c < 40; c++) begin
         valid_in = ($urandom_range(0, 3) != 0);
         data_in  = $urandom;
         if (valid_in) begin
            l_d[sel] = data_in;
            l_v[sel] = 1'b1;
         end else begin
            l_v[sel] = 1'b0;
         end
         sel = ~sel;
         step();
         n_cmp++;
         if (o_ld[3][63:0] !== {l_d[1], l_d[0]} || o_lv[3][1:0] !== {l_v[1], l_v[0]}) begin
            n_bad++; $display("FAIL legacy c%0d: got v=%b d=%h want v=%b%b d=%h", c, o_lv[3][1:0], o_ld[3][63:0], l_v[1], l_v[0], {l_d[1], l_d[0]});
         end
      end
      valid_in = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         reset    = ($urandom_range(0, 59) == 0);
         valid_in = ($urandom_range(0, 9) < 7);
         data_in  = $urandom;
         for (int m = 0; m < NI; m++) begin
            for (int b = 0; b < 8; b++) rdy[m][b] = ($urandom_range(0, 3) != 0);
         end
         #1;
         for (int m = 0; m < NI; m++) begin
            n_cmp++;
            if (o_ir[m] !== rdy[m][mp[m]]) begin
               n_bad++; $display("FAIL rnd_in_ready[%0d] c%0d: got %b want %b", m, c, o_ir[m], rdy[m][mp[m]]);
            end
         end
         step();
         for (int m = 0; m < NI; m++) begin
            n_cmp++;
            if (o_ptr[m] !== 3'(mp[m]) || o_gs[m] !== mg[m]) begin
               n_bad++; $display("FAIL rnd_ptr_gs[%0d] c%0d: got p=%0d gs=%b want p=%0d gs=%b", m, c, o_ptr[m], o_gs[m], mp[m], mg[m]);
            end
            for (int k = 0; k < lanes_of(m); k++) begin
               n_cmp++;
               if (o_ld[m][k*32 +: 32] !== md[m][k] || o_lv[m][k] !== mv[m][k]) begin
                  n_bad++; $display("FAIL rnd_lane[%0d][%0d] c%0d: got v=%b d=%h want v=%b d=%h", m, k, c, o_lv[m][k], o_ld[m][k*32 +: 32], mv[m][k], md[m][k]);
               end
            end
         end
      end
      reset    = 1'b0;
      valid_in = 1'b0;
   endtask

   initial begin
      reset    = 1'b1;
      valid_in = 1'b0;
      data_in  = '0;
      for (int m = 0; m < NI; m++) rdy[m] = 8'hFF;
      test_reset();
      test_fixed_rotation();
      test_idle_policy();
      test_three_lanes();
      test_backpressure();
      test_reset_midstream();
      test_legacy();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
